rf_wb_arbiter: RTL and testbench

Shares the register file's single write port between two writeback sources (src0: ALU result, src1: memory/load result). Accepts one write per cycle through valid/ready handshakes, picks a winner with round-robin priority, and drives the register file write port from a registered output stage. It sits between the execute/memory stages and the 4 x 16-bit register file. It also reports which register has a write in flight.

---
 rtl/rf_pkg.sv | 6 +
 rtl/rr_arb2.sv | 20 ++
 rtl/rf_wb_arbiter.sv | 80 ++++++++
 tb/tb_rf_wb_arbiter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared register-file geometry for the writeback path.
package rf_pkg;
  localparam int WORD_SIZE = 16;
  localparam int ADDR_W    = 2;
  localparam int NUM_REGS  = 2 ** ADDR_W;
endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; owns the last_grant history bit.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  output logic [1:0] grant,
  output logic       last_grant
);
  // On a tie the source that did not win last time goes first.
  always_comb begin
    grant = req;
    if (&req) grant = last_grant ? 2'b01 : 2'b10;
  end

  // Reset to 1 so src0 wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    last_grant <= 1'b1;
    else if (|grant) last_grant <= grant[1];
  end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the RF write port between ALU (src0) and load (src1) writebacks.
// Optional same-cycle read bypass is built when RF_WB_BYPASS_EN is defined.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int WORD_SIZE = rf_pkg::WORD_SIZE,
  parameter int ADDR_W    = rf_pkg::ADDR_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   src0_valid,
  output logic                   src0_ready,
  input  logic [ADDR_W-1:0]      src0_addr,
  input  logic [WORD_SIZE-1:0]   src0_data,
  input  logic                   src1_valid,
  output logic                   src1_ready,
  input  logic [ADDR_W-1:0]      src1_addr,
  input  logic [WORD_SIZE-1:0]   src1_data,
`ifdef RF_WB_BYPASS_EN
  input  logic [ADDR_W-1:0]      rd_addr1,
  input  logic [ADDR_W-1:0]      rd_addr2,
  input  logic [WORD_SIZE-1:0]   rf_data1,
  input  logic [WORD_SIZE-1:0]   rf_data2,
  output logic [WORD_SIZE-1:0]   fwd_data1,
  output logic [WORD_SIZE-1:0]   fwd_data2,
`endif
  output logic                   rf_write,
  output logic [ADDR_W-1:0]      rf_addr3,
  output logic [WORD_SIZE-1:0]   rf_data3,
  output logic [2**ADDR_W-1:0]   wb_pending,
  output logic                   last_grant
);
  localparam int NR = 2 ** ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0]    addr;
    logic [WORD_SIZE-1:0] data;
  } wb_req_t;

  wb_req_t [1:0] src;
  wb_req_t       win;
  logic    [1:0] grant;

  assign src[0] = '{addr: src0_addr, data: src0_data};
  assign src[1] = '{addr: src1_addr, data: src1_data};

  rr_arb2 u_arb (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        ({src1_valid, src0_valid}),
    .grant      (grant),
    .last_grant (last_grant)
  );

  // Grant implies valid, so ready doubles as the transfer strobe.
  assign src0_ready = grant[0];
  assign src1_ready = grant[1];
  assign win        = src[grant[1]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_write <= 1'b0;
      rf_addr3 <= '0;
      rf_data3 <= '0;
    end else begin
      rf_write <= |grant;
      if (|grant) begin
        rf_addr3 <= win.addr;
        rf_data3 <= win.data;
      end
    end
  end

  assign wb_pending = rf_write ? (NR'(1) << rf_addr3) : '0;

`ifdef RF_WB_BYPASS_EN
  assign fwd_data1 = (rf_write && rf_addr3 == rd_addr1) ? rf_data3 : rf_data1;
  assign fwd_data2 = (rf_write && rf_addr3 == rd_addr2) ? rf_data3 : rf_data2;
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter with a behavioural 4x16 register file.
module tb_rf_wb_arbiter;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        src0_valid, src0_ready, src1_valid, src1_ready;
  logic [1:0]  src0_addr, src1_addr, rf_addr3;
  logic [15:0] src0_data, src1_data, rf_data3;
  logic        rf_write, last_grant;
  logic [3:0]  wb_pending;
`ifdef RF_WB_BYPASS_EN
  logic [1:0]  rd_addr1, rd_addr2;
  logic [15:0] rf_data1, rf_data2, fwd_data1, fwd_data2;
`endif
  logic [15:0] rf_model [4];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .src0_valid (src0_valid),
    .src0_ready (src0_ready),
    .src0_addr  (src0_addr),
    .src0_data  (src0_data),
    .src1_valid (src1_valid),
    .src1_ready (src1_ready),
    .src1_addr  (src1_addr),
    .src1_data  (src1_data),
`ifdef RF_WB_BYPASS_EN
    .rd_addr1   (rd_addr1),
    .rd_addr2   (rd_addr2),
    .rf_data1   (rf_data1),
    .rf_data2   (rf_data2),
    .fwd_data1  (fwd_data1),
    .fwd_data2  (fwd_data2),
`endif
    .rf_write   (rf_write),
    .rf_addr3   (rf_addr3),
    .rf_data3   (rf_data3),
    .wb_pending (wb_pending),
    .last_grant (last_grant)
  );

  // Register file: not reset, always accepts.
  always @(posedge clk) if (rf_write) rf_model[rf_addr3] <= rf_data3;

  task automatic test_reset();
    reset_n = 1'b0; src0_valid = 0; src1_valid = 0;
    src0_addr = 0; src0_data = 0; src1_addr = 0; src1_data = 0;
    #12;
    checks++; if (rf_write !== 1'b0) begin errors++; $display("FAIL reset_rf_write got=%b exp=0", rf_write); end
    checks++; if (rf_addr3 !== 2'd0) begin errors++; $display("FAIL reset_rf_addr3 got=%0d exp=0", rf_addr3); end
    checks++; if (rf_data3 !== 16'h0) begin errors++; $display("FAIL reset_rf_data3 got=%h exp=0000", rf_data3); end
    checks++; if (last_grant !== 1'b1) begin errors++; $display("FAIL reset_last_grant got=%b exp=1", last_grant); end
    checks++; if (wb_pending !== 4'b0) begin errors++; $display("FAIL reset_wb_pending got=%b exp=0000", wb_pending); end
    src1_valid = 1; #1;
    checks++; if ({src1_ready, src0_ready} !== 2'b10) begin errors++; $display("FAIL reset_ready_comb got=%b exp=10", {src1_ready, src0_ready}); end
    src1_valid = 0;
    @(negedge clk); reset_n = 1'b1;
  endtask

  // Both valid with last_grant=1: src0 then src1, one write per cycle.
  task automatic test_back_to_back();
    @(negedge clk);
    src0_valid = 1; src0_addr = 0; src0_data = 16'h0001;
    src1_valid = 1; src1_addr = 1; src1_data = 16'h0002;
    #1;
    checks++; if ({src1_ready, src0_ready} !== 2'b01) begin errors++; $display("FAIL b2b_ready1 got=%b exp=01", {src1_ready, src0_ready}); end
    @(posedge clk); #1; src0_valid = 0;
    checks++; if ({rf_write, rf_addr3, rf_data3} !== {1'b1, 2'd0, 16'h0001}) begin errors++; $display("FAIL b2b_out1 got=%b/%0d/%h exp=1/0/0001", rf_write, rf_addr3, rf_data3); end
    checks++; if (wb_pending !== 4'b0001) begin errors++; $display("FAIL b2b_pend1 got=%b exp=0001", wb_pending); end
    #1;
    checks++; if ({src1_ready, src0_ready} !== 2'b10) begin errors++; $display("FAIL b2b_ready2 got=%b exp=10", {src1_ready, src0_ready}); end
    @(posedge clk); #1; src1_valid = 0;
    checks++; if ({rf_write, rf_addr3, rf_data3} !== {1'b1, 2'd1, 16'h0002}) begin errors++; $display("FAIL b2b_out2 got=%b/%0d/%h exp=1/1/0002", rf_write, rf_addr3, rf_data3); end
    checks++; if (wb_pending !== 4'b0010) begin errors++; $display("FAIL b2b_pend2 got=%b exp=0010", wb_pending); end
    checks++; if (last_grant !== 1'b1) begin errors++; $display("FAIL b2b_last_grant got=%b exp=1", last_grant); end
    // Continuous contention must alternate every cycle.
    src0_valid = 1; src1_valid = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({src1_ready, src0_ready} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL b2b_alternate cycle=%0d got=%b exp=%b", i, {src1_ready, src0_ready}, (i % 2 == 0) ? 2'b01 : 2'b10);
      end
      @(posedge clk); #1;
    end
    src0_valid = 0; src1_valid = 0;
    @(posedge clk); #1;
    checks++; if (rf_model[0] !== 16'h0001 || rf_model[1] !== 16'h0002) begin errors++; $display("FAIL b2b_rf got=%h/%h exp=0001/0002", rf_model[0], rf_model[1]); end
  endtask

  task automatic test_single();
    @(negedge clk);
    src0_valid = 1; src0_addr = 2; src0_data = 16'hBEEF; #1;
    checks++; if ({src1_ready, src0_ready} !== 2'b01) begin errors++; $display("FAIL single_ready got=%b exp=01", {src1_ready, src0_ready}); end
    @(posedge clk); #1; src0_valid = 0;
    checks++; if ({rf_write, rf_addr3, rf_data3} !== {1'b1, 2'd2, 16'hBEEF}) begin errors++; $display("FAIL single_out got=%b/%0d/%h exp=1/2/beef", rf_write, rf_addr3, rf_data3); end
    checks++; if (wb_pending !== 4'b0100) begin errors++; $display("FAIL single_pend got=%b exp=0100", wb_pending); end
    checks++; if (last_grant !== 1'b0) begin errors++; $display("FAIL single_last_grant got=%b exp=0", last_grant); end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({rf_write, wb_pending, rf_addr3, rf_data3} !== {1'b0, 4'b0, 2'd2, 16'hBEEF}) begin
        errors++; $display("FAIL idle cycle=%0d got=%b/%b/%0d/%h exp=0/0000/2/beef", i, rf_write, wb_pending, rf_addr3, rf_data3);
      end
    end
    checks++; if (rf_model[2] !== 16'hBEEF) begin errors++; $display("FAIL idle_rf2 got=%h exp=beef", rf_model[2]); end
  endtask

  // last_grant=0 here, so src1 is written first and src0 lands last.
  task automatic test_same_addr();
    @(negedge clk);
    src0_valid = 1; src0_addr = 3; src0_data = 16'h1111;
    src1_valid = 1; src1_addr = 3; src1_data = 16'h2222; #1;
    checks++; if ({src1_ready, src0_ready} !== 2'b10) begin errors++; $display("FAIL same_ready1 got=%b exp=10", {src1_ready, src0_ready}); end
    @(posedge clk); #1; src1_valid = 0;
    checks++; if ({rf_write, rf_addr3, rf_data3} !== {1'b1, 2'd3, 16'h2222}) begin errors++; $display("FAIL same_out1 got=%b/%0d/%h exp=1/3/2222", rf_write, rf_addr3, rf_data3); end
    #1;
    checks++; if ({src1_ready, src0_ready} !== 2'b01) begin errors++; $display("FAIL same_ready2 got=%b exp=01", {src1_ready, src0_ready}); end
    @(posedge clk); #1; src0_valid = 0;
    checks++; if ({rf_write, rf_addr3, rf_data3} !== {1'b1, 2'd3, 16'h1111}) begin errors++; $display("FAIL same_out2 got=%b/%0d/%h exp=1/3/1111", rf_write, rf_addr3, rf_data3); end
    @(posedge clk); #1;
    checks++; if (rf_model[3] !== 16'h1111) begin errors++; $display("FAIL same_rf3 got=%h exp=1111", rf_model[3]); end
  endtask

  // Reset between the transfer and the RF edge must drop the write.
  task automatic test_mid_reset();
    @(negedge clk);
    src0_valid = 1; src0_addr = 1; src0_data = 16'h7777;
    @(posedge clk); #1; src0_valid = 0;
    checks++; if (rf_write !== 1'b1) begin errors++; $display("FAIL midrst_pre got=%b exp=1", rf_write); end
    #2; reset_n = 1'b0; #1;
    checks++; if ({rf_write, wb_pending, last_grant} !== {1'b0, 4'b0, 1'b1}) begin errors++; $display("FAIL midrst_out got=%b/%b/%b exp=0/0000/1", rf_write, wb_pending, last_grant); end
    @(posedge clk); #1;
    checks++; if (rf_model[1] !== 16'h0002) begin errors++; $display("FAIL midrst_rf1 got=%h exp=0002", rf_model[1]); end
    @(negedge clk); reset_n = 1'b1;
  endtask

`ifdef RF_WB_BYPASS_EN
  task automatic test_bypass();
    rd_addr1 = 1; rd_addr2 = 0; rf_data1 = 16'h1234; rf_data2 = 16'h5678;
    @(negedge clk); #1;
    checks++; if (fwd_data1 !== 16'h1234) begin errors++; $display("FAIL byp_idle got=%h exp=1234", fwd_data1); end
    src0_valid = 1; src0_addr = 1; src0_data = 16'hA5A5;
    @(posedge clk); #1; src0_valid = 0;
    checks++; if (fwd_data1 !== 16'hA5A5) begin errors++; $display("FAIL byp_fwd1 got=%h exp=a5a5", fwd_data1); end
    checks++; if (fwd_data2 !== 16'h5678) begin errors++; $display("FAIL byp_fwd2 got=%h exp=5678", fwd_data2); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 4; i++) rf_model[i] = 16'h0;
`ifdef RF_WB_BYPASS_EN
    rd_addr1 = 0; rd_addr2 = 0; rf_data1 = 0; rf_data2 = 0;
`endif
    test_reset();
    test_back_to_back();
    test_single();
    test_idle();
    test_same_addr();
    test_mid_reset();
`ifdef RF_WB_BYPASS_EN
    test_bypass();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
